// File: rtl/am_search_ctrl.sv
// am_search_ctrl: sequences the AM tree adder over every class/chunk and
// returns the argmax class with a start/done handshake.
module am_search_ctrl #(
  parameter int NUM_CLASSES   = 26,
  parameter int CHUNKS_PER_HV = 10,
  parameter int SIM_W         = 13,
  parameter int CLS_W         = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1,
  parameter int CHK_W         = (CHUNKS_PER_HV > 1) ? $clog2(CHUNKS_PER_HV) : 1
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIM_W-1:0] similarity_value,
  output logic [CLS_W-1:0] am_class_idx,
  output logic [CHK_W-1:0] am_chunk_idx,
  output logic             comparing_query_hv_with_class_hv,
  output logic             inferring_class,
  output logic             busy,
  output logic             done,
  output logic [CLS_W-1:0] predicted_class,
  output logic [SIM_W-1:0] best_similarity
);
  typedef enum logic [2:0] {IDLE, ACCUM, COMPARE, CLEAR, DONE} state_t;
  localparam logic [CLS_W-1:0] LAST_CLS = CLS_W'(NUM_CLASSES - 1);
  localparam logic [CHK_W-1:0] LAST_CHK = CHK_W'(CHUNKS_PER_HV - 1);
  state_t state_q, state_d;
  logic [CLS_W-1:0] cls_q, cls_d, pred_q, pred_d;
  logic [CHK_W-1:0] chk_q, chk_d;
  logic [SIM_W-1:0] best_q, best_d;
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
      cls_q   <= '0;
      chk_q   <= '0;
      pred_q  <= '0;
      best_q  <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      chk_q   <= chk_d;
      pred_q  <= pred_d;
      best_q  <= best_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    chk_d   = chk_q;
    pred_d  = pred_q;
    best_d  = best_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = ACCUM;
        cls_d   = '0;
        chk_d   = '0;
        pred_d  = '0;
        best_d  = '0;
      end
      ACCUM: begin
        state_d = (chk_q == LAST_CHK) ? COMPARE : ACCUM;
        chk_d   = (chk_q == LAST_CHK) ? '0 : chk_q + CHK_W'(1);
      end
      COMPARE: begin
        // strict compare keeps the lower index on ties
        if (cls_q == '0 || similarity_value > best_q) begin
          pred_d = cls_q;
          best_d = similarity_value;
        end
        state_d = (cls_q == LAST_CLS) ? DONE : CLEAR;
      end
      CLEAR: begin
        cls_d   = cls_q + CLS_W'(1);
        state_d = ACCUM;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      cls_d   = '0;
      chk_d   = '0;
    end
  end
  assign am_class_idx                    = cls_q;
  assign am_chunk_idx                    = chk_q;
  assign comparing_query_hv_with_class_hv = (state_q == ACCUM);
  assign inferring_class                 = (state_q == COMPARE);
  assign busy                            = (state_q != IDLE);
  assign done                            = (state_q == DONE);
  assign predicted_class                 = pred_q;
  assign best_similarity                 = best_q;
endmodule

// File: doc/am_search_ctrl.md
# am_search_ctrl

Sequencer for associative-memory (AM) search. Steps the shared AM popcount tree adder/accumulator through every class hypervector, chunk by chunk, and drives its `comparing_query_hv_with_class_hv` and `inferring_class` controls. It runs an argmax over the per-class similarity values and returns the predicted class with a start/done handshake. It sits between the top-level inference FSM and the AM memory plus tree-adder datapath.

## Interface
- `NUM_CLASSES`, default 26: number of class HVs stored in AM (≥1).
- `CHUNKS_PER_HV`, default 10: AM chunks per HV (500 dims per chunk gives 5000 dims).
- `SIM_W`, default 13: similarity width, matching the accumulator output.
- `CLS_W`, default `$clog2(NUM_CLASSES)` (min 1); `CHK_W`, default `$clog2(CHUNKS_PER_HV)` (min 1).
- `clk` in 1: clock, rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `start` in 1: request a search; sampled in IDLE only.
- `abort` in 1: synchronous cancel; return to IDLE without `done`.
- `similarity_value` in SIM_W: accumulator output from the tree adder.
- `am_class_idx` out CLS_W: AM class address, registered.
- `am_chunk_idx` out CHK_W: AM chunk address, registered.
- `comparing_query_hv_with_class_hv` out 1: accumulate enable to the adder.
- `inferring_class` out 1: hold enable to the adder.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a search completes.
- `predicted_class` out CLS_W: argmax class index.
- `best_similarity` out SIM_W: similarity of `predicted_class`.

## Operation
- States: IDLE, ACCUM, COMPARE, CLEAR, DONE.
- Reset: all outputs 0. State is IDLE, with `cls_cnt` and `chk_cnt` both 0.
- IDLE: all adder controls low, so the accumulator is held at 0.
  - `start`=1 goes to ACCUM, with `am_class_idx`=0, `am_chunk_idx`=0, and `best_similarity`/`predicted_class` cleared to 0.
- ACCUM: `comparing`=1, lasting exactly CHUNKS_PER_HV cycles. `am_chunk_idx` increments each cycle.
  - Address and `comparing` are aligned in the same cycle; the AM read plus AND array is combinational to the adder.
  - After the last chunk (`chk_cnt`=CHUNKS_PER_HV-1), go to COMPARE and wrap `am_chunk_idx` to 0.
- COMPARE: `inferring_class`=1, `comparing`=0, so the accumulator holds.
  - Update `best_similarity` and `predicted_class` if `am_class_idx`==0, or if `similarity_value` > `best_similarity` (strict, unsigned).
  - Ties keep the lower index.
  - If `am_class_idx`==NUM_CLASSES-1, go to DONE. Otherwise go to CLEAR.
- CLEAR: both adder controls low, so the accumulator resets to 0 at the end of this cycle. `am_class_idx` increments, then go to ACCUM.
- DONE: `done`=1 for one cycle, then go to IDLE. `predicted_class`/`best_similarity` stay stable until the next accepted `start`.
- `start` while `busy` is ignored. `start` asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.
- `abort`=1 in any non-IDLE state goes to IDLE next cycle, and takes priority over all other transitions.
  - No `done`. Adder controls drop low, which clears the accumulator.
  - `predicted_class`/`best_similarity` are left as partially updated; they are undefined for use.
- `nrst` asserted mid-search: immediate return to reset values, with no `done`.
- Counter wrap: the class and chunk counters never exceed NUM_CLASSES-1 / CHUNKS_PER_HV-1.
- Width rule: the controller does not check for overflow. The adder guarantees the sum fits in SIM_W.

## Timing
- Cycle 0 is the edge that samples `start`. ACCUM occupies cycles 1..C, where C = CHUNKS_PER_HV.
- Class k has COMPARE at cycle k·(C+2)+C+1 and CLEAR at k·(C+2)+C+2.
- `done` is high in cycle NUM_CLASSES·(C+2). With defaults that is cycle 312; `busy` then falls at cycle 313.
- `similarity_value` sampled in COMPARE reflects all C chunks of the current class, since the accumulator registered the last chunk at the ACCUM→COMPARE edge.
- Back-to-back: `start` held high from the `done` cycle onward is accepted in the first IDLE cycle. Minimum gap is 1 IDLE cycle.

## Test plan
- Defaults, model adder returning per-class sums {5,900,17,…,0} with class 1 maximal → `done` at cycle 312, `predicted_class`=1, `best_similarity`=900.
- Tie: classes 3 and 7 both equal 4000, all others lower → `predicted_class`=3.
- All classes 0 → `predicted_class`=0, `best_similarity`=0. Also check `done` is exactly one cycle wide.
- NUM_CLASSES=1, C=1 → ACCUM 1 cycle, COMPARE, DONE at cycle 3. Check `am_class_idx`=0 throughout and that CLEAR is never entered.
- `abort` in class 5 ACCUM → IDLE next cycle, no `done`, controls low. A following `start` gives a correct full search.
- `nrst` pulsed during COMPARE → all outputs 0 immediately. `start` during `busy` ignored: no restart, and `done` timing unchanged.
